// File: rtl/axis_width_combine.sv
// rtl/axis_width_combine.sv - packs pairs of 256-bit AXI-Stream beats into 512-bit beats
module axis_width_combine #(
    parameter int S_DATA_WIDTH = 256,
    parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
    parameter int M_DATA_WIDTH = 2 * S_DATA_WIDTH,
    parameter int M_KEEP_WIDTH = 2 * S_KEEP_WIDTH
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    keep_err
);

    // LO: next accepted beat is the lower half; HI: lower half is held
    typedef enum logic {
        LO = 1'b0,
        HI = 1'b1
    } state_t;

    state_t                  state;
    logic [S_DATA_WIDTH-1:0] hold_data;
    logic [S_KEEP_WIDTH-1:0] hold_keep;
    logic                    out_free;
    logic                    accept;
    logic                    partial_keep;

    // Output register can take a new beat when empty or draining this cycle.
    // tready is kept independent of tdata/tlast, so it is out_free in both states.
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = out_free;
    assign accept        = s_axis_tvalid && out_free;
    assign partial_keep  = (s_axis_tkeep != {S_KEEP_WIDTH{1'b1}});

    // Lower/upper half sequencing; any tlast returns to LO so packets never share a beat
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state <= LO;
        end else if (accept) begin
            if (state == LO) begin
                state <= s_axis_tlast ? LO : HI;
            end else begin
                state <= LO;
            end
        end
    end

    // Capture the earlier beat of a pair; it stays put while the output is stalled
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            hold_data <= '0;
            hold_keep <= '0;
        end else if (accept && state == LO && !s_axis_tlast) begin
            hold_data <= s_axis_tdata;
            hold_keep <= s_axis_tkeep;
        end
    end

    // Output register: loads on a completing beat, clears valid when drained, freezes when stalled
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (out_free) begin
            m_axis_tvalid <= 1'b0;
            if (accept) begin
                if (state == HI) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= {s_axis_tdata, hold_data};
                    m_axis_tkeep  <= {s_axis_tkeep, hold_keep};
                    m_axis_tlast  <= s_axis_tlast;
                end else if (s_axis_tlast) begin
                    // Odd-length packet end: upper half zero-filled with no keep bits
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= {{S_DATA_WIDTH{1'b0}}, s_axis_tdata};
                    m_axis_tkeep  <= {{S_KEEP_WIDTH{1'b0}}, s_axis_tkeep};
                    m_axis_tlast  <= 1'b1;
                end
            end
        end
    end

    // Informational pulse for a non-last beat that does not fill all byte lanes
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            keep_err <= 1'b0;
        end else begin
            keep_err <= accept && !s_axis_tlast && partial_keep;
        end
    end

endmodule

// File: tb/tb_axis_width_combine.sv
// tb/tb_axis_width_combine.sv - vector table plus randomized stream against a packing model
module tb_axis_width_combine;

    logic         clk;
    logic         rst;
    logic         s_tvalid;
    logic         s_tready;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic         s_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic         m_tlast;
    logic         kerr;

    int tests;
    int fails;

    axis_width_combine dut (
        .axis_aclk     (clk),
        .axis_areset   (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .keep_err      (kerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          v;
        logic [31:0] tag;
        logic [31:0] keep;
        bit          last;
        bit          mr;
        bit          exp_srdy;
        bit          exp_mv;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [63:0] exp_keep;
        bit          exp_last;
        bit          exp_kerr;
    } vec_t;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        bit           last;
    } obeat_t;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        bit           last;
    } ibeat_t;

    localparam logic [31:0] KF = 32'hFFFF_FFFF;

    vec_t   vecs[19];
    ibeat_t ins[$];
    obeat_t exp_q[$];
    logic [255:0] pend_data;
    logic [31:0]  pend_keep;
    bit           pend_valid;

    function automatic logic [255:0] pat(input logic [31:0] tag);
        return {8{tag}};
    endfunction

    function automatic vec_t mk(input bit r, input bit v, input logic [31:0] tag, input logic [31:0] keep,
                                input bit last, input bit mr, input bit srdy, input bit mv,
                                input logic [31:0] hi, input logic [31:0] lo, input logic [63:0] ek,
                                input bit el, input bit ke);
        vec_t x;
        x.rst = r; x.v = v; x.tag = tag; x.keep = keep; x.last = last; x.mr = mr;
        x.exp_srdy = srdy; x.exp_mv = mv; x.exp_hi = hi; x.exp_lo = lo;
        x.exp_keep = ek; x.exp_last = el; x.exp_kerr = ke;
        return x;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference packing: pairs beats per packet, lower half first, odd tail zero-filled
    task automatic model_accept(input logic [255:0] d, input logic [31:0] k, input bit l);
        obeat_t o;
        if (pend_valid) begin
            o.data = {d, pend_data};
            o.keep = {k, pend_keep};
            o.last = l;
            exp_q.push_back(o);
            pend_valid = 0;
        end else if (l) begin
            o.data = {256'd0, d};
            o.keep = {32'd0, k};
            o.last = 1'b1;
            exp_q.push_back(o);
        end else begin
            pend_data  = d;
            pend_keep  = k;
            pend_valid = 1;
        end
    endtask

    initial begin
        logic [255:0] rd;
        logic [31:0]  rk;
        int  plen;
        int  sent;
        int  low_cnt;
        int  cyc;
        bit  acc;
        bit  mhs;
        bit  stall;
        bit  exp_k;
        bit  snap_last;
        logic [511:0] snap_data;
        logic [63:0]  snap_keep;
        ibeat_t b;

        tests = 0;
        fails = 0;

        //         rst v  tag           keep          last mr srdy mv hi            lo            ekeep                  el ke
        vecs[0]  = mk(1, 0, 32'h0,        KF,           0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[1]  = mk(0, 1, 32'hA000_00A0, KF,          0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[2]  = mk(0, 1, 32'hA000_00A1, KF,          0, 1, 1,  1, 32'hA000_00A1, 32'hA000_00A0, {KF, KF},           0, 0);
        vecs[3]  = mk(0, 1, 32'hA000_00A2, KF,          0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[4]  = mk(0, 1, 32'hA000_00A3, KF,          1, 1, 1,  1, 32'hA000_00A3, 32'hA000_00A2, {KF, KF},           1, 0);
        vecs[5]  = mk(0, 1, 32'hB000_00B0, KF,          0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[6]  = mk(0, 1, 32'hB000_00B1, KF,          0, 1, 1,  1, 32'hB000_00B1, 32'hB000_00B0, {KF, KF},           0, 0);
        vecs[7]  = mk(0, 1, 32'hB000_00B2, 32'h0000_FFFF, 1, 1, 1, 1, 32'h0,        32'hB000_00B2, 64'h0000_0000_0000_FFFF, 1, 0);
        vecs[8]  = mk(0, 1, 32'hC000_00C0, KF,          1, 1, 1,  1, 32'h0,        32'hC000_00C0, {32'h0, KF},         1, 0);
        vecs[9]  = mk(0, 0, 32'h0,        KF,           0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[10] = mk(0, 1, 32'hD000_00D0, 32'h7FFF_FFFF, 0, 1, 1, 0, 32'h0,       32'h0,        64'h0,                 0, 1);
        vecs[11] = mk(0, 1, 32'hD000_00D1, KF,          1, 1, 1,  1, 32'hD000_00D1, 32'hD000_00D0, {KF, 32'h7FFF_FFFF}, 1, 0);
        vecs[12] = mk(0, 1, 32'hE000_00E0, KF,          0, 0, 0,  1, 32'hD000_00D1, 32'hD000_00D0, {KF, 32'h7FFF_FFFF}, 1, 0);
        vecs[13] = mk(0, 1, 32'hE000_00E0, KF,          0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[14] = mk(1, 0, 32'h0,        KF,           0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[15] = mk(0, 1, 32'hF000_00F0, KF,          0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[16] = mk(0, 1, 32'hF000_00F1, KF,          1, 1, 1,  1, 32'hF000_00F1, 32'hF000_00F0, {KF, KF},           1, 0);
        vecs[17] = mk(0, 1, 32'h1000_0010, KF,          0, 1, 1,  0, 32'h0,        32'h0,        64'h0,                 0, 0);
        vecs[18] = mk(0, 1, 32'h1000_0011, KF,          1, 0, 1,  1, 32'h1000_0011, 32'h1000_0010, {KF, KF},           1, 0);

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; s_tvalid = vecs[i].v; s_tdata = pat(vecs[i].tag);
            s_tkeep = vecs[i].keep; s_tlast = vecs[i].last; m_tready = vecs[i].mr;
            #1;
            check($sformatf("v%0d s_tready", i), {511'd0, s_tready}, {511'd0, vecs[i].exp_srdy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d m_tvalid", i), {511'd0, m_tvalid}, {511'd0, vecs[i].exp_mv});
            check($sformatf("v%0d keep_err", i), {511'd0, kerr}, {511'd0, vecs[i].exp_kerr});
            if (vecs[i].exp_mv || vecs[i].rst) begin
                check($sformatf("v%0d m_tdata", i), m_tdata, {pat(vecs[i].exp_hi), pat(vecs[i].exp_lo)});
                check($sformatf("v%0d m_tkeep", i), {448'd0, m_tkeep}, {448'd0, vecs[i].exp_keep});
                check($sformatf("v%0d m_tlast", i), {511'd0, m_tlast}, {511'd0, vecs[i].exp_last});
            end
        end

        // Reset between directed and random phases; model starts empty
        @(negedge clk);
        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend_valid = 0;

        // Build a 64-beat stream of random-length packets
        sent = 0;
        while (ins.size() < 64) begin
            plen = $urandom_range(1, 6);
            for (int j = 0; j < plen && ins.size() < 64; j++) begin
                for (int w = 0; w < 8; w++) rd[w*32 +: 32] = $urandom;
                b.data = rd;
                b.last = (j == plen - 1) || (ins.size() == 63);
                case ($urandom_range(0, 7))
                    0: rk = 32'h7FFF_FFFF;
                    1: rk = 32'h0000_FFFF;
                    2: rk = 32'h0000_0001;
                    default: rk = KF;
                endcase
                b.keep = rk;
                ins.push_back(b);
            end
        end

        low_cnt = 0;
        cyc = 0;
        while ((sent < 64 || exp_q.size() != 0 || m_tvalid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 20) low_cnt = 10;
            if (low_cnt > 0) begin
                m_tready = 1'b0;
                low_cnt--;
            end else if ($urandom_range(0, 15) == 0) begin
                low_cnt = 10;
                m_tready = 1'b0;
            end else begin
                m_tready = ($urandom_range(0, 3) != 0);
            end
            if (sent < 64 && $urandom_range(0, 4) != 0) begin
                s_tvalid = 1'b1;
                s_tdata  = ins[sent].data;
                s_tkeep  = ins[sent].keep;
                s_tlast  = ins[sent].last;
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            acc   = s_tvalid && s_tready;
            mhs   = m_tvalid && m_tready;
            stall = m_tvalid && !m_tready;
            snap_data = m_tdata; snap_keep = m_tkeep; snap_last = m_tlast;
            if (stall) check("rand s_tready low while output full", {511'd0, s_tready}, 512'd0);
            if (mhs) begin
                if (exp_q.size() == 0) begin
                    check("rand unexpected output beat", 512'd1, 512'd0);
                end else begin
                    check("rand m_tdata", m_tdata, exp_q[0].data);
                    check("rand m_tkeep/tlast", {447'd0, m_tkeep, m_tlast}, {447'd0, exp_q[0].keep, exp_q[0].last});
                    void'(exp_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
            exp_k = acc && !s_tlast && (s_tkeep != KF);
            check("rand keep_err", {511'd0, kerr}, {511'd0, exp_k});
            if (stall) begin
                check("rand stall stable", {m_tvalid, m_tdata}, {1'b1, snap_data});
                check("rand stall stable keep/last", {447'd0, m_tkeep, m_tlast}, {447'd0, snap_keep, snap_last});
            end
            if (acc) begin
                model_accept(s_tdata, s_tkeep, s_tlast);
                sent++;
            end
        end
        check("rand all beats accepted", sent, 64);
        check("rand all outputs drained", exp_q.size(), 0);
        check("rand no leftover lower half", {511'd0, pend_valid}, 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
